// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state type and the default
// operand width. Optional feature macro used by div_unit: DIV_SIGNED_EN.
package div_pkg;

   // Default operand/result width in bits.
   localparam int unsigned DivWidthDefault = 32;

   // Divider control states.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StFinish = 2'd2
   } divState_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the partial remainder left
// by one, bring in the next dividend bit, and subtract the divisor when that
// does not borrow. The partial remainder is WIDTH+1 bits wide so the compare
// never sees a truncated value.
module div_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DivWidthDefault
) (
   input  logic [WIDTH:0]   remIn,
   input  logic             dvdBit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   remOut,
   output logic             qBit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // Trial subtraction; the top bit of the difference is the borrow.
   always_comb begin
      shifted = {remIn, dvdBit};
      diff    = shifted - {2'b00, divisor};
      qBit    = ~diff[WIDTH+1];
      remOut  = qBit ? diff[WIDTH:0] : shifted[WIDTH:0];
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider. A start in IDLE with a non-zero divisor runs
// WIDTH restoring steps and updates hi (remainder) / lo (quotient) with a
// one-cycle done pulse; a zero divisor instead pulses div0 and leaves hi/lo
// untouched. Define DIV_SIGNED_EN for two's-complement signed division
// (quotient toward zero, remainder follows the dividend's sign); otherwise
// operands are treated as unsigned. Latency is the same in both builds.
module div_unit
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DivWidthDefault
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   divState_e        stateQ;
   logic [CntW-1:0]  countQ;
   logic [WIDTH:0]   remQ;
   // Dividend bits shift out of the top while quotient bits shift in below.
   logic [WIDTH-1:0] dvdQ;
   logic [WIDTH-1:0] dsrQ;

   logic [WIDTH:0]   remNext;
   logic             qBit;
   logic [WIDTH-1:0] quotRaw;
   logic [WIDTH-1:0] remRaw;
   logic [WIDTH-1:0] quotFinal;
   logic [WIDTH-1:0] remFinal;
   logic [WIDTH-1:0] aMag;
   logic [WIDTH-1:0] bMag;

   div_step #(
      .WIDTH (WIDTH)
   ) uStep (
      .remIn   (remQ),
      .dvdBit  (dvdQ[WIDTH-1]),
      .divisor (dsrQ),
      .remOut  (remNext),
      .qBit    (qBit)
   );

   // Raw result of the last step, valid on the final RUN cycle.
   always_comb begin
      quotRaw = {dvdQ[WIDTH-2:0], qBit};
      remRaw  = remNext[WIDTH-1:0];
   end

`ifdef DIV_SIGNED_EN
   logic negQuotQ;
   logic negRemQ;

   // Operand magnitudes; the most negative value maps onto itself, which is
   // the correct unsigned magnitude 2^(WIDTH-1).
   always_comb begin
      aMag = a[WIDTH-1] ? -a : a;
      bMag = b[WIDTH-1] ? -b : b;
   end

   // Remember the result signs of the accepted operands.
   always_ff @(posedge clk) begin
      if (reset) begin
         negQuotQ <= 1'b0;
         negRemQ  <= 1'b0;
      end else if (stateQ == StIdle && start) begin
         negQuotQ <= a[WIDTH-1] ^ b[WIDTH-1];
         negRemQ  <= a[WIDTH-1];
      end
   end

   // Sign correction of the unsigned magnitudes.
   always_comb begin
      quotFinal = negQuotQ ? -quotRaw : quotRaw;
      remFinal  = negRemQ  ? -remRaw  : remRaw;
   end
`else
   // Unsigned build: operands and results pass through unchanged.
   always_comb begin
      aMag      = a;
      bMag      = b;
      quotFinal = quotRaw;
      remFinal  = remRaw;
   end
`endif

   // Control FSM with registered busy/done/div0 and result registers.
   // The last RUN step writes the corrected result so that done and the new
   // hi/lo appear together in the FINISH cycle; busy drops when leaving FINISH.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= StIdle;
         countQ <= '0;
         remQ   <= '0;
         dvdQ   <= '0;
         dsrQ   <= '0;
         hi     <= '0;
         lo     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         div0   <= 1'b0;
      end else begin
         done <= 1'b0;
         div0 <= 1'b0;
         unique case (stateQ)
            StIdle: begin
               if (start) begin
                  if (b == '0) begin
                     div0 <= 1'b1;
                  end else begin
                     remQ   <= '0;
                     dvdQ   <= aMag;
                     dsrQ   <= bMag;
                     countQ <= CntW'(WIDTH);
                     busy   <= 1'b1;
                     stateQ <= StRun;
                  end
               end
            end
            StRun: begin
               remQ   <= remNext;
               dvdQ   <= quotRaw;
               countQ <= countQ - CntW'(1);
               if (countQ == CntW'(1)) begin
                  hi     <= remFinal;
                  lo     <= quotFinal;
                  done   <= 1'b1;
                  stateQ <= StFinish;
               end
            end
            StFinish: begin
               busy   <= 1'b0;
               stateQ <= StIdle;
            end
            default: begin
               busy   <= 1'b0;
               stateQ <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request from control unit divControl path; sampled only in IDLE.
REQ-005 a  input  WIDTH  dividend, taken from A register; sampled on accepted start.
REQ-006 b  input  WIDTH  divisor, taken from B register; sampled on accepted start.
REQ-007 hi  output  WIDTH  remainder; feeds the HIdiv register.
REQ-008 lo  output  WIDTH  quotient; feeds the LOdiv register.
REQ-009 busy  output  1  high while a division is in progress.
REQ-010 done  output  1  one-cycle pulse when hi/lo hold a new valid result.
REQ-011 div0  output  1  one-cycle pulse on divide-by-zero; consumed by control unit exception logic.

Function
REQ-012 FSM states SHALL be IDLE, RUN, FINISH.
REQ-013 IDLE + start + b!=0: latch operand magnitudes, clear partial remainder, load counter = WIDTH, go RUN, busy=1 next cycle.
REQ-014 IDLE + start + b==0: div0=1 next cycle for exactly one cycle; stay IDLE; hi/lo unchanged; done not asserted.
REQ-015 RUN: one restoring-division step per cycle (shift remainder/dividend left 1; subtract divisor if no borrow; shift quotient bit in); decrement counter.
REQ-016 RUN with counter reaching 0 SHALL go FINISH; FINISH applies sign correction, updates hi/lo, pulses done, returns to IDLE.
REQ-017 Latency: start accepted at cycle 0 -> done high at cycle WIDTH+1 (33 for default); busy high cycles 1..WIDTH+1.
REQ-018 start while busy SHALL be ignored; no queuing.
REQ-019 start in the same cycle done is high SHALL be ignored (FSM not yet in IDLE).
REQ-020 hi/lo SHALL hold last result until the next done; intermediate values never visible.
REQ-021 Internal arithmetic SHALL use WIDTH+1 bits for the partial remainder; no truncation before compare.

Reset
REQ-022 reset SHALL force IDLE, hi=0, lo=0, busy=0, done=0, div0=0, counter=0.
REQ-023 reset mid-RUN SHALL abort with no done or div0 pulse; reset has priority over start.

Configuration
REQ-024 Macro DIV_SIGNED_EN defined: two's-complement signed division; quotient truncates toward zero, remainder takes dividend's sign; 0x80000000 / -1 yields lo=0x80000000, hi=0.
REQ-025 DIV_SIGNED_EN undefined: unsigned division on raw operands; sign correction logic absent; latency unchanged.

Structure
REQ-026 Shared package div_pkg SHALL hold the FSM state enum and the WIDTH default constant.
REQ-027 One sub-module div_step (combinational single restoring step: remainder, dividend bit, divisor -> next remainder, quotient bit) is natural; FSM, counter and registers stay in div_unit.

Verification
REQ-028 a=100, b=7, start at cycle 0 -> done at cycle 33, lo=14, hi=2, busy low at cycle 34.
REQ-029 a=5, b=0, start -> div0 high cycle 1 only; busy/done stay 0; hi/lo keep previous values.
REQ-030 DIV_SIGNED_EN: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); unsigned build: lo=0x7FFFFFFC, hi=1.
REQ-031 DIV_SIGNED_EN: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, no div0.
REQ-032 Start 100/7, second start (a=9, b=3) at cycle 5 -> ignored; result lo=14, hi=2 at cycle 33.
REQ-033 Start 100/7, reset at cycle 10 -> cycle 11 busy=0, hi=lo=0, no done through cycle 40.
